// File: rtl/pio_sequencer_if.sv
// Host TX push handshake between host logic and the pio sequencer.
// The host is the master; the sequencer answers with push_ready.
interface pio_sequencer_if;
    logic        push_valid;
    logic [1:0]  push_mindex;
    logic [31:0] push_data;
    logic        push_ready;

    modport master (
        output push_valid,
        output push_mindex,
        output push_data,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_mindex,
        input  push_data,
        output push_ready
    );
endinterface

// File: rtl/pio_sequencer.sv
// Boot loader (program ROM, then config ROM) and run-time TX forwarder
// for a single pio instance.
module pio_sequencer #(
    parameter int PROG_LEN   = 32,
    parameter int CONF_LEN   = 5,
    parameter int ACT_PROG   = 1,
    parameter int ACT_PUSH   = 4,
    parameter int AUTO_START = 1
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                start,
    output logic [4:0]          prog_addr,
    input  logic [15:0]         prog_data,
    output logic [4:0]          conf_addr,
    input  logic [37:0]         conf_data,
    pio_sequencer_if.slave      host,
    input  logic [3:0]          tx_full,
    output logic [5:0]          action,
    output logic [31:0]         din,
    output logic [4:0]          index,
    output logic [1:0]          mindex,
    output logic                busy,
    output logic                loaded
);

    typedef enum logic [1:0] {IDLE, PROG, CONF, RUN} state_t;
    typedef enum logic [1:0] {K_NONE, K_PROG, K_CONF, K_PUSH} kind_t;

    localparam logic [4:0] L_PLAST = 5'(PROG_LEN - 1);
    localparam logic [4:0] L_CLAST = 5'(CONF_LEN - 1);

    state_t      r_state;
    kind_t       r_kind;
    logic        r_armed;
    logic        r_drain;
    logic        r_hold;
    logic [4:0]  r_prog_addr;
    logic [4:0]  r_conf_addr;
    logic [4:0]  r_index;
    logic [31:0] r_din;
    logic [1:0]  r_mindex;

    logic w_start;
    logic w_ready;
    logic w_accept;

    assign w_start  = start & r_armed;
    assign w_ready  = (r_state == RUN) & ~start
                    & ~tx_full[host.push_mindex] & ~r_hold;
    assign w_accept = w_ready & host.push_valid;

    assign host.push_ready = w_ready;

    // r_kind tags what the ROM/host pipeline presents this cycle;
    // r_drain holds the section open while its last word is shown.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= IDLE;
            r_kind      <= K_NONE;
            r_armed     <= 1'b0;
            r_drain     <= 1'b0;
            r_hold      <= 1'b0;
            r_prog_addr <= '0;
            r_conf_addr <= '0;
            r_index     <= '0;
            r_din       <= '0;
            r_mindex    <= '0;
        end else begin
            r_armed <= 1'b1;
            r_hold  <= w_accept;
            r_kind  <= K_NONE;
            if (w_start) begin
                r_state     <= PROG;
                r_prog_addr <= '0;
                r_conf_addr <= '0;
                r_drain     <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (!r_armed && AUTO_START != 0)
                            r_state <= PROG;
                    end
                    PROG: begin
                        if (r_drain) begin
                            r_drain <= 1'b0;
                            r_state <= RUN;
                        end else begin
                            r_kind  <= K_PROG;
                            r_index <= r_prog_addr;
                            if (r_prog_addr == L_PLAST) begin
                                if (CONF_LEN == 0)
                                    r_drain <= 1'b1;
                                else
                                    r_state <= CONF;
                            end else begin
                                r_prog_addr <= r_prog_addr + 5'd1;
                            end
                        end
                    end
                    CONF: begin
                        if (r_drain) begin
                            r_drain <= 1'b0;
                            r_state <= RUN;
                        end else begin
                            r_kind  <= K_CONF;
                            r_index <= r_conf_addr;
                            if (r_conf_addr == L_CLAST)
                                r_drain <= 1'b1;
                            else
                                r_conf_addr <= r_conf_addr + 5'd1;
                        end
                    end
                    RUN: begin
                        if (w_accept) begin
                            r_kind   <= K_PUSH;
                            r_din    <= host.push_data;
                            r_mindex <= host.push_mindex;
                            r_index  <= '0;
                        end
                    end
                endcase
            end
        end
    end

    // ROM words are taken straight off the sync ROM output register.
    always_comb begin
        action = '0;
        din    = '0;
        mindex = '0;
        unique case (r_kind)
            K_PROG: begin
                action = 6'(ACT_PROG);
                din    = {16'h0, prog_data};
            end
            K_CONF: begin
                action = {2'b00, conf_data[35:32]};
                din    = conf_data[31:0];
                mindex = conf_data[37:36];
            end
            K_PUSH: begin
                action = 6'(ACT_PUSH);
                din    = r_din;
                mindex = r_mindex;
            end
            default: ;
        endcase
    end

    assign prog_addr = r_prog_addr;
    assign conf_addr = r_conf_addr;
    assign index     = r_index;
    assign busy      = (r_state == PROG) | (r_state == CONF);
    assign loaded    = (r_state == RUN);

endmodule

// File: tb/tb_pio_sequencer.sv
// Randomized scoreboard bench for pio_sequencer: boot sequence, host
// pushes with tx_full throttling, restarts and asynchronous reset.
module tb_pio_sequencer;

    localparam int PL = 32;
    localparam int CL = 5;

    typedef struct {
        logic [5:0]  act;
        logic [31:0] din;
        logic [4:0]  idx;
        logic [1:0]  mi;
        int          cyc;
        bit          chk_idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  conf_addr;
    logic [37:0] conf_data;
    logic [3:0]  tx_full;
    logic [5:0]  action;
    logic [31:0] din;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic        busy;
    logic        loaded;

    pio_sequencer_if bus ();

    pio_sequencer #(
        .PROG_LEN   (PL),
        .CONF_LEN   (CL),
        .ACT_PROG   (1),
        .ACT_PUSH   (4),
        .AUTO_START (1)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .conf_addr (conf_addr),
        .conf_data (conf_data),
        .host      (bus),
        .tx_full   (tx_full),
        .action    (action),
        .din       (din),
        .index     (index),
        .mindex    (mindex),
        .busy      (busy),
        .loaded    (loaded)
    );

    always #5 clk = ~clk;

    logic [15:0] prom [PL];
    logic [37:0] crom [32];

    always @(posedge clk) begin
        prog_data <= prom[prog_addr];
        conf_data <= crom[conf_addr];
    end

    int cyc;
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    exp_t q[$];
    exp_t mon_e;
    int   nerr = 0;
    int   nchk = 0;
    int   base = 0;
    int   run_at = 0;
    bit   hold_m = 1'b0;
    bit   last_acc = 1'b0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Expected boot writes when start (or reset release) is seen in cycle b.
    task automatic push_boot(input int b);
        exp_t e;
        for (int i = 0; i < PL; i++) begin
            e.act = 6'd1;
            e.din = {16'h0, prom[i]};
            e.idx = 5'(i);
            e.mi = 2'd0;
            e.cyc = b + 2 + i;
            e.chk_idx = 1'b1;
            q.push_back(e);
        end
        for (int j = 0; j < CL; j++) begin
            if (crom[j][35:32] != 4'h0) begin
                e.act = {2'b00, crom[j][35:32]};
                e.din = crom[j][31:0];
                e.idx = 5'(j);
                e.mi = crom[j][37:36];
                e.cyc = b + 2 + PL + j;
                e.chk_idx = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input bit v, input logic [1:0] m,
                        input logic [31:0] d, input logic [3:0] tf,
                        input bit st);
        bit er;
        bit acc;
        int c;
        exp_t e;
        bus.push_valid = v;
        bus.push_mindex = m;
        bus.push_data = d;
        tx_full = tf;
        start = st;
        @(negedge clk);
        c = cyc;
        er = (c >= run_at) && !st && !tf[m] && !hold_m;
        check("push_ready", 32'(bus.push_ready), 32'(er));
        check("loaded", 32'(loaded), 32'(c >= run_at));
        check("busy", 32'(busy), 32'(c > base && c < run_at));
        acc = v && er;
        last_acc = acc;
        if (acc) begin
            e.act = 6'd4;
            e.din = d;
            e.idx = 5'd0;
            e.mi = m;
            e.cyc = c + 1;
            e.chk_idx = 1'b0;
            q.push_back(e);
        end
        hold_m = acc;
        if (st) begin
            while (q.size() > 0 && q[q.size() - 1].cyc > c)
                void'(q.pop_back());
            base = c;
            run_at = c + PL + CL + 2;
            push_boot(c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_action"}, 32'(action), 32'd0);
        check({tag, "_din"}, din, 32'd0);
        check({tag, "_index"}, 32'(index), 32'd0);
        check({tag, "_mindex"}, 32'(mindex), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_loaded"}, 32'(loaded), 32'd0);
        check({tag, "_prog_addr"}, 32'(prog_addr), 32'd0);
        check({tag, "_conf_addr"}, 32'(conf_addr), 32'd0);
        check({tag, "_push_ready"}, 32'(bus.push_ready), 32'd0);
    endtask

    always @(negedge clk) begin
        if (n_reset && action != 6'd0) begin
            if (q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_write cyc=%0d got=%0h exp=none",
                         cyc, action);
            end else begin
                mon_e = q.pop_front();
                check("wr_cycle", cyc, mon_e.cyc);
                check("wr_action", 32'(action), 32'(mon_e.act));
                check("wr_din", din, mon_e.din);
                check("wr_mindex", 32'(mindex), 32'(mon_e.mi));
                if (mon_e.chk_idx)
                    check("wr_index", 32'(index), 32'(mon_e.idx));
            end
        end
    end

    initial begin
        int k;
        n_reset = 1'b0;
        start = 1'b0;
        tx_full = 4'h0;
        bus.push_valid = 1'b0;
        bus.push_mindex = 2'd0;
        bus.push_data = 32'd0;
        for (int i = 0; i < PL; i++) prom[i] = 16'($urandom);
        for (int j = 0; j < 32; j++)
            crom[j] = {2'($urandom), 4'($urandom_range(1, 15)), 32'($urandom)};
        crom[2] = {2'b00, 4'h4, 32'h12345678};
        crom[3] = {2'($urandom), 4'h0, 32'($urandom)};

        repeat (3) @(negedge clk);
        check_zero("reset");

        n_reset = 1'b1;
        base = 0;
        run_at = PL + CL + 2;
        push_boot(0);
        @(posedge clk);
        #1;

        // restart while write index 10 is on the pio bus
        while (cyc < 12) step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
        step(1'b1, 2'd3, 32'hdead_beef, 4'h0, 1'b1);
        while (cyc < run_at) step(1'b1, 2'd1, 32'h0bad_0bad, 4'h0, 1'b0);
        step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);

        k = 1;
        for (int n = 0; n < 12 && k <= 3; n++) begin
            step(1'b1, 2'd1, 32'(k), 4'h0, 1'b0);
            if (last_acc) k++;
        end
        check("directed_accepts", 32'(k), 32'd4);
        step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);

        repeat (3) step(1'b1, 2'd2, 32'ha5a5_0002, 4'b0100, 1'b0);
        step(1'b1, 2'd2, 32'ha5a5_0002, 4'b0000, 1'b0);
        step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);

        for (int n = 0; n < 80; n++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 32'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 1'b0);

        // reload from RUN with a host word offered, then reset mid-CONF
        step(1'b1, 2'd1, 32'h5555_aaaa, 4'h0, 1'b1);
        while (cyc < base + 35) step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
        #2;
        n_reset = 1'b0;
        #1;
        check_zero("async_rst");
        q.delete();
        hold_m = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        base = 0;
        run_at = PL + CL + 2;
        push_boot(0);
        @(posedge clk);
        #1;
        while (cyc < run_at + 1) step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
        for (int n = 0; n < 30; n++)
            step($urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)),
                 32'($urandom), 4'h0, 1'b0);
        repeat (3) step(1'b0, 2'd0, 32'd0, 4'h0, 1'b0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
